// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// ram_port_arbiter : round-robin sequencer sharing one RAM port, with write-ack retry
// Optional: `define ARB_RETRY_EN to re-issue un-acked writes up to MAX_RETRY times
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      ram_wr_en,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic                      ram_wr_ack,
  input  logic [DATA_W-1:0]         ram_rd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2,
    RESP  = 2'd3
  } state_t;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_param
      $error("ram_port_arbiter: parameter out of range");
    end
  endgenerate

  state_t             r_state;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_we;

`ifdef ARB_RETRY_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
  logic [3:0]         r_retry_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
`endif

  logic               w_any;
  logic [IDX_W-1:0]   w_gnt;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_we;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan downwards so the requester closest to rr_ptr overwrites the others.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_addr  = req_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
  assign w_wdata = req_wdata[int'(w_gnt)*DATA_W +: DATA_W];
  assign w_we    = req_we[w_gnt];

  // Accept is combinational so the grant lands in the IDLE cycle itself.
  assign req_ready = (reset_n && (r_state == IDLE) && w_any) ? onehot(w_gnt) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_we        <= 1'b0;
`ifdef ARB_RETRY_EN
      r_retry_cnt <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
`endif
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt       <= w_gnt;
            r_we        <= w_we;
`ifdef ARB_RETRY_EN
            r_retry_cnt <= '0;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
`endif
            // The port registers double as the command latch for the first attempt.
            ram_wr_en   <= w_we;
            ram_rd_en   <= ~w_we;
            ram_addr    <= w_addr;
            ram_wdata   <= w_we ? w_wdata : '0;
            r_state     <= ISSUE;
          end
        end

        ISSUE: begin
          ram_wr_en <= 1'b0;
          ram_rd_en <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          if (r_we) begin
            r_state <= ACK;
          end else begin
            rsp_rdata <= ram_rd_data;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(r_gnt);
            r_state   <= RESP;
          end
        end

        ACK: begin
          if (ram_wr_ack) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(r_gnt);
            r_state   <= RESP;
`ifdef ARB_RETRY_EN
          end else if (r_retry_cnt < RETRY_LIMIT) begin
            r_retry_cnt <= r_retry_cnt + 4'd1;
            ram_wr_en   <= 1'b1;
            ram_addr    <= r_addr;
            ram_wdata   <= r_wdata;
            r_state     <= ISSUE;
`endif
          end else begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(r_gnt);
            r_state   <= RESP;
          end
        end

        RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          r_rr_ptr  <= wrap_idx(r_gnt, 1);
          r_state   <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_port_arbiter : scoreboard bench with a behavioural RAM port and ack injection
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 8;
  localparam int MAX_RETRY = 3;
`ifdef ARB_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      ram_wr_en;
  logic                      ram_rd_en;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic                      ram_wr_ack;
  logic [DATA_W-1:0]         ram_rd_data;
  logic [37:0]               outs;

  assign outs = {req_ready, rsp_valid, rsp_rdata, rsp_err, ram_wr_en, ram_rd_en, ram_addr, ram_wdata};

  ram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wr_ack(ram_wr_ack), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                lat;
    int                issues;
  } exp_t;

  exp_t              exp_q[$];
  int                grants[$];
  logic [DATA_W-1:0] shadow[int];
  int checks = 0, errors = 0;
  int cyc = 0, accept_cyc = 0, issue_cnt = 0;
  int accept_count = 0, resp_count = 0;
  int wr_count = 0, nack_until = 0;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    logic [31:0] v;
    v = 32'(a) * 32'd13 + 32'd7;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural RAM port: writes land unless a nack is pending, ack one cycle later.
  logic [DATA_W-1:0] mem   [0:(1<<ADDR_W)-1];
  logic              wmask [0:(1<<ADDR_W)-1];
  assign ram_rd_data = wmask[ram_addr] ? mem[ram_addr] : init_val(ram_addr);

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    ram_wr_ack <= 1'b0;
    if (ram_wr_en) begin
      wr_count <= wr_count + 1;
      if (wr_count >= nack_until) begin
        mem[ram_addr]   <= ram_wdata;
        wmask[ram_addr] <= 1'b1;
        ram_wr_ack      <= 1'b1;
      end
    end
  end

  // Monitor: grants, port activity and scoreboard compare on responses.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (ram_wr_en || ram_rd_en) issue_cnt++;
        if (req_ready != '0) begin
          if (rsp_valid != '0) chk("ready_rsp_overlap", rsp_valid, 0);
          chk("ready_onehot", $countones(req_ready), 1);
          for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) grants.push_back(i);
          accept_cyc = cyc;
          issue_cnt  = 0;
          accept_count++;
        end
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, 64'(1) << e.idx);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("latency", cyc - accept_cyc, e.lat);
            chk("issue_pulses", issue_cnt, e.issues);
          end
          resp_count++;
        end
      end
    end
  end

  task automatic wait_accepts(input int n);
    int t = 0;
    while (accept_count < n && t < 300) begin
      @(negedge clk); #1; t++;
    end
    chk("accept_wait", accept_count, n);
  endtask

  task automatic wait_resps(input int n);
    int t = 0;
    while (resp_count < n && t < 300) begin
      @(negedge clk); #1; t++;
    end
    chk("resp_wait", resp_count, n);
  endtask

  task automatic drive(input int idx, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[idx]                    = 1'b1;
    req_we[idx]                       = we;
    req_addr[idx*ADDR_W +: ADDR_W]    = a;
    req_wdata[idx*DATA_W +: DATA_W]   = d;
  endtask

  function automatic exp_t mk_read(input int idx, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.idx = idx; e.rdata = exp_rd(a); e.err = 1'b0; e.lat = 2; e.issues = 1;
    return e;
  endfunction

  // Single command from one requester, expectation derived from the nack count.
  task automatic cmd(input int idx, input logic we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input int nacks);
    exp_t e;
    int a0, r0;
    a0 = accept_count;
    r0 = resp_count;
    if (we) begin
      e.idx = idx; e.rdata = '0;
      if (nacks <= RETRIES) begin
        e.err = 1'b0; e.issues = nacks + 1; shadow[int'(a)] = d;
      end else begin
        e.err = 1'b1; e.issues = RETRIES + 1;
      end
      e.lat = 1 + 2 * e.issues;
    end else begin
      e = mk_read(idx, a);
    end
    exp_q.push_back(e);
    nack_until = wr_count + nacks;
    @(posedge clk); #1;
    drive(idx, we, a, d);
    wait_accepts(a0 + 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    wait_resps(r0 + 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a0, r0;
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    reset_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs, 0);
    reset_n = 1'b1;

    // Continuous reads from all four requesters straight out of reset.
    grants.delete();
    a0 = accept_count; r0 = resp_count;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk_read(rr_exp[i], 11'h100 + 11'(rr_exp[i])));
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b0, 11'h100 + 11'(i), '0);
    wait_accepts(a0 + 5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resps(r0 + 5);
    chk("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_grant_order", grants[i], rr_exp[i]);

    // Write/read round trip, conflict retry and persistent conflict.
    cmd(0, 1'b1, 11'h123, 8'hA5, 0);
    cmd(0, 1'b0, 11'h123, 8'h00, 0);
    cmd(0, 1'b1, 11'h055, 8'h3C, 2);
    cmd(0, 1'b1, 11'h066, 8'hC3, 100);
    cmd(0, 1'b0, 11'h055, 8'h00, 0);
    cmd(0, 1'b0, 11'h066, 8'h00, 0);
    cmd(2, 1'b1, 11'h7FF, 8'hFF, 0);
    cmd(1, 1'b0, 11'h7FF, 8'h00, 0);

    // Withdrawal: req2 pulses valid while req1 is busy and must never be granted.
    grants.delete();
    a0 = accept_count; r0 = resp_count;
    exp_q.push_back(mk_read(1, 11'h020));
    exp_q.push_back(mk_read(3, 11'h021));
    @(posedge clk); #1;
    drive(1, 1'b0, 11'h020, '0);
    wait_accepts(a0 + 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drive(2, 1'b0, 11'h022, '0);
    drive(3, 1'b0, 11'h021, '0);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_accepts(a0 + 2);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_resps(r0 + 2);
    chk("wd_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("wd_grant_first", grants[0], 1);
      chk("wd_grant_next", grants[1], 3);
    end

    // Reset mid-ISSUE of a write; pointer must return to requester 0.
    cmd(2, 1'b0, 11'h030, 8'h00, 0);
    grants.delete();
    a0 = accept_count; r0 = resp_count;
    nack_until = wr_count;
    @(posedge clk); #1;
    drive(3, 1'b1, 11'h300, 8'h77);
    wait_accepts(a0 + 1);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    chk("issue_before_reset", ram_wr_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs, 0);
    drive(0, 1'b0, 11'h010, '0);
    drive(3, 1'b0, 11'h011, '0);
    #1;
    chk("ready_in_reset", req_ready, 0);
    exp_q.push_back(mk_read(0, 11'h010));
    exp_q.push_back(mk_read(3, 11'h011));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_accepts(a0 + 2);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_accepts(a0 + 3);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_resps(r0 + 2);
    chk("post_reset_grants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("post_reset_first", grants[1], 0);
      chk("post_reset_second", grants[2], 3);
    end
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
